// File: rtl/sys_array_sched.sv
// Operand scheduler for the 2x2 systolic array: buffers A rows / B columns, streams
// them to the array edges with a one-handshake skew, then waits for the PEs to finish.
module sys_array_sched #(
  parameter int N_MAX    = 8,
  parameter int DW       = 32,
  parameter int DRAIN_TO = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [$clog2(N_MAX):0]   k_len,
  input  logic                     ld_en,
  input  logic [1:0]               ld_sel,
  input  logic [$clog2(N_MAX)-1:0] ld_idx,
  input  logic [DW-1:0]            ld_dat,
  output logic [DW-1:0]            a1_dat,
  output logic [DW-1:0]            a2_dat,
  output logic [DW-1:0]            b1_dat,
  output logic [DW-1:0]            b2_dat,
  output logic                     a1_valid,
  output logic                     a2_valid,
  output logic                     b1_valid,
  output logic                     b2_valid,
  input  logic                     a1_ready,
  input  logic                     a2_ready,
  input  logic                     b1_ready,
  input  logic                     b2_ready,
  input  logic [3:0]               pe_comp_done,
  input  logic [3:0]               pe_error,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err,
  output logic                     run_err
);
  localparam int KW = $clog2(N_MAX) + 1;
  localparam int IW = $clog2(N_MAX);
  localparam int TW = $clog2(DRAIN_TO + 1);
  localparam logic [KW-1:0] KMAX = KW'(N_MAX);
  localparam logic [TW-1:0] DTO  = TW'(DRAIN_TO);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d, cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [TW-1:0] drn_q, drn_d;
  logic          g2_q, g2_d, cfg_q, cfg_d, run_q, run_d;
  logic [DW-1:0] buf_q [4][N_MAX];

  logic v1, v2, hs1, hs2, wr_en, k_ok;

  // Group 2 trails group 1 by one handshake via g2_q.
  assign v1    = (state_q == S_FEED) && (cnt1_q < k_q);
  assign v2    = (state_q == S_FEED) && g2_q && (cnt2_q < k_q);
  assign hs1   = v1 && a1_ready && b1_ready;
  assign hs2   = v2 && a2_ready && b2_ready;
  assign wr_en = (state_q == S_IDLE) && ld_en;
  assign k_ok  = (k_len != '0) && (k_len <= KMAX);

  assign a1_valid = v1;
  assign b1_valid = v1;
  assign a2_valid = v2;
  assign b2_valid = v2;
  assign a1_dat   = v1 ? buf_q[0][cnt1_q[IW-1:0]] : '0;
  assign b1_dat   = v1 ? buf_q[2][cnt1_q[IW-1:0]] : '0;
  assign a2_dat   = v2 ? buf_q[1][cnt2_q[IW-1:0]] : '0;
  assign b2_dat   = v2 ? buf_q[3][cnt2_q[IW-1:0]] : '0;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign cfg_err  = cfg_q;
  assign run_err  = run_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    drn_d   = drn_q;
    g2_d    = g2_q;
    cfg_d   = cfg_q;
    run_d   = run_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (k_ok) begin
            k_d     = k_len;
            cfg_d   = 1'b0;
            run_d   = 1'b0;
            cnt1_d  = '0;
            cnt2_d  = '0;
            drn_d   = '0;
            g2_d    = 1'b0;
            state_d = S_FEED;
          end else begin
            cfg_d = 1'b1;
          end
        end
      end
      S_FEED: begin
        if (pe_error != 4'b0) run_d = 1'b1;
        if (hs1) begin
          cnt1_d = cnt1_q + KW'(1);
          g2_d   = 1'b1;
        end
        if (hs2) cnt2_d = cnt2_q + KW'(1);
        if ((cnt1_d == k_q) && (cnt2_d == k_q)) begin
          drn_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pe_error != 4'b0) run_d = 1'b1;
        drn_d = drn_q + TW'(1);
        // Completion takes priority over a timeout landing in the same cycle.
        if (pe_comp_done == 4'b1111) begin
          state_d = S_DONE;
        end else if (drn_d == DTO) begin
          run_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      drn_q   <= '0;
      g2_q    <= 1'b0;
      cfg_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      drn_q   <= drn_d;
      g2_q    <= g2_d;
      cfg_q   <= cfg_d;
      run_q   <= run_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 4; s++)
        for (int e = 0; e < N_MAX; e++)
          buf_q[s][e] <= '0;
    end else if (wr_en) begin
      buf_q[ld_sel][ld_idx] <= ld_dat;
    end
  end

endmodule

// File: tb/tb_sys_array_sched.sv
// Self-checking bench for sys_array_sched: queue-style reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_sys_array_sched;
  localparam int N_MAX    = 8;
  localparam int DW       = 32;
  localparam int DRAIN_TO = 64;

  localparam logic [31:0] F1 = 32'h3F800000, F2 = 32'h40000000, F3 = 32'h40400000;
  localparam logic [31:0] F4 = 32'h40800000, F5 = 32'h40A00000, F6 = 32'h40C00000;
  localparam logic [31:0] F9 = 32'h41100000;

  logic          clk = 1'b0;
  logic          rst, start, ld_en;
  logic [3:0]    k_len;
  logic [1:0]    ld_sel;
  logic [2:0]    ld_idx;
  logic [DW-1:0] ld_dat;
  logic [DW-1:0] a1_dat, a2_dat, b1_dat, b2_dat;
  logic          a1_valid, a2_valid, b1_valid, b2_valid;
  logic          a1_ready, a2_ready, b1_ready, b2_ready;
  logic [3:0]    pe_comp_done, pe_error;
  logic          busy, done, cfg_err, run_err;

  always #5 clk = ~clk;

  sys_array_sched #(.N_MAX(N_MAX), .DW(DW), .DRAIN_TO(DRAIN_TO)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .ld_en(ld_en), .ld_sel(ld_sel), .ld_idx(ld_idx), .ld_dat(ld_dat),
    .a1_dat(a1_dat), .a2_dat(a2_dat), .b1_dat(b1_dat), .b2_dat(b2_dat),
    .a1_valid(a1_valid), .a2_valid(a2_valid), .b1_valid(b1_valid), .b2_valid(b2_valid),
    .a1_ready(a1_ready), .a2_ready(a2_ready), .b1_ready(b1_ready), .b2_ready(b2_ready),
    .pe_comp_done(pe_comp_done), .pe_error(pe_error),
    .busy(busy), .done(done), .cfg_err(cfg_err), .run_err(run_err)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: how many operands each edge group has delivered, and which phase
  // the computation is in.
  logic [31:0] mbuf [4][N_MAX];
  bit m_feed, m_drain, m_done, m_g2, m_cfg, m_run;
  int m_k, m_n1, m_n2, m_dcnt;

  task automatic model_step();
    bit v1, v2;
    if (rst) begin
      m_feed = 0; m_drain = 0; m_done = 0; m_g2 = 0; m_cfg = 0; m_run = 0;
      m_k = 0; m_n1 = 0; m_n2 = 0; m_dcnt = 0;
      for (int s = 0; s < 4; s++)
        for (int e = 0; e < N_MAX; e++) mbuf[s][e] = '0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_feed) begin
      v1 = (m_n1 < m_k);
      v2 = m_g2 && (m_n2 < m_k);
      if (pe_error != 0) m_run = 1;
      if (v1 && a1_ready && b1_ready) begin m_n1++; m_g2 = 1; end
      if (v2 && a2_ready && b2_ready) m_n2++;
      if (m_n1 == m_k && m_n2 == m_k) begin m_feed = 0; m_drain = 1; m_dcnt = 0; end
    end else if (m_drain) begin
      if (pe_error != 0) m_run = 1;
      m_dcnt++;
      if (pe_comp_done == 4'hF) begin m_drain = 0; m_done = 1; end
      else if (m_dcnt == DRAIN_TO) begin m_run = 1; m_drain = 0; m_done = 1; end
    end else begin
      if (ld_en) mbuf[ld_sel][ld_idx] = ld_dat;
      if (start) begin
        if (k_len >= 1 && k_len <= N_MAX) begin
          m_k = int'(k_len); m_n1 = 0; m_n2 = 0; m_g2 = 0;
          m_cfg = 0; m_run = 0; m_feed = 1;
        end else begin
          m_cfg = 1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process
  initial forever begin
    bit ev1, ev2;
    logic [31:0] ea1, eb1, ea2, eb2;
    @(negedge clk);
    if (chk_en) begin
      ev1 = m_feed && (m_n1 < m_k);
      ev2 = m_feed && m_g2 && (m_n2 < m_k);
      ea1 = '0; eb1 = '0; ea2 = '0; eb2 = '0;
      if (ev1) begin ea1 = mbuf[0][m_n1]; eb1 = mbuf[2][m_n1]; end
      if (ev2) begin ea2 = mbuf[1][m_n2]; eb2 = mbuf[3][m_n2]; end
      chk("a1_valid", a1_valid, ev1);
      chk("b1_valid", b1_valid, ev1);
      chk("a2_valid", a2_valid, ev2);
      chk("b2_valid", b2_valid, ev2);
      chk("a1_dat", a1_dat, ea1);
      chk("b1_dat", b1_dat, eb1);
      chk("a2_dat", a2_dat, ea2);
      chk("b2_dat", b2_dat, eb2);
      chk("busy", busy, m_feed | m_drain | m_done);
      chk("done", done, m_done);
      chk("cfg_err", cfg_err, m_cfg);
      chk("run_err", run_err, m_run);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input logic [1:0] sel, input int idx, input logic [31:0] dat);
    ld_en = 1; ld_sel = sel; ld_idx = 3'(idx); ld_dat = dat;
    tick();
    ld_en = 0;
  endtask

  task automatic load_nominal();
    logic [31:0] v [6];
    v = '{F1, F2, F3, F4, F5, F6};
    for (int i = 0; i < 3; i++) begin
      load(2'd0, i, v[i]);
      load(2'd1, i, v[i+3]);
      load(2'd2, i, v[i]);
      load(2'd3, i, v[i+3]);
    end
  endtask

  // Returns one cycle into FEED (cycle t+1).
  task automatic do_start(input int k);
    start = 1; k_len = 4'(k);
    tick();
    start = 0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin tick(); n++; end
    chk(name, done, 1'b1);
    tick();
  endtask

  initial begin
    int n;
    rst = 1; start = 0; k_len = 0; ld_en = 0; ld_sel = 0; ld_idx = 0; ld_dat = 0;
    a1_ready = 1; a2_ready = 1; b1_ready = 1; b2_ready = 1;
    pe_comp_done = 0; pe_error = 0;
    tick(); tick();
    chk_en = 1;
    tick();
    chk("reset busy", busy, 1'b0);
    chk("reset a1_valid", a1_valid, 1'b0);
    chk("reset a1_dat", a1_dat, 32'h0);
    chk("reset cfg_err", cfg_err, 1'b0);
    rst = 0;
    tick();

    // Nominal K=3
    load_nominal();
    do_start(3);
    chk("nom t1 a1", a1_dat, F1);
    chk("nom t1 a2_valid", a2_valid, 1'b0);
    tick();
    chk("nom t2 a1", a1_dat, F2);
    chk("nom t2 a2", a2_dat, F4);
    tick();
    chk("nom t3 a1", a1_dat, F3);
    chk("nom t3 b2", b2_dat, F5);
    tick();
    chk("nom t4 a1_valid", a1_valid, 1'b0);
    chk("nom t4 a2", a2_dat, F6);
    tick();
    chk("nom t5 drain a2_valid", a2_valid, 1'b0);
    chk("nom t5 busy", busy, 1'b1);
    tick(); tick(); tick();
    pe_comp_done = 4'hF;
    chk("nom t8 done", done, 1'b0);
    tick();
    chk("nom t9 done", done, 1'b1);
    pe_comp_done = 4'h0;
    tick();
    chk("nom t10 done", done, 1'b0);
    chk("nom t10 busy", busy, 1'b0);

    // Ignored ld_en during FEED and start during DRAIN
    pe_comp_done = 4'hF;
    do_start(3);
    ld_en = 1; ld_sel = 0; ld_idx = 0; ld_dat = F9;
    tick();
    ld_en = 0;
    tick(); tick(); tick();
    chk("ign drain busy", busy, 1'b1);
    start = 1; k_len = 4'd2;
    tick();
    start = 0;
    wait_done("ign done", 20);
    chk("ign no restart", busy, 1'b0);
    do_start(1);
    chk("ign reread A1[0]", a1_dat, F1);
    wait_done("ign2 done", 20);

    // Backpressure on b1
    do_start(3);
    tick();
    b1_ready = 0;
    chk("bp t2 a1", a1_dat, F2);
    tick(); tick();
    chk("bp t4 a1", a1_dat, F2);
    chk("bp t4 b1", b1_dat, F2);
    chk("bp t4 a2", a2_dat, F6);
    tick();
    b1_ready = 1;
    chk("bp t5 a1", a1_dat, F2);
    wait_done("bp done", 30);

    // Illegal configuration
    do_start(0);
    chk("cfg k0 err", cfg_err, 1'b1);
    chk("cfg k0 busy", busy, 1'b0);
    do_start(9);
    chk("cfg k9 err", cfg_err, 1'b1);
    chk("cfg k9 valid", a1_valid, 1'b0);
    tick();
    chk("cfg no done", done, 1'b0);
    do_start(2);
    chk("cfg cleared", cfg_err, 1'b0);
    wait_done("cfg done", 20);

    // Drain timeout
    pe_comp_done = 4'b0111;
    do_start(1);
    n = 1;
    while (!done && n < 200) begin tick(); n++; end
    chk("timeout latency", 32'(n), 32'(1 + 2 + DRAIN_TO));
    chk("timeout run_err", run_err, 1'b1);
    tick();
    pe_comp_done = 4'hF;

    // PE error during FEED
    do_start(4);
    tick();
    pe_error = 4'b0100;
    tick();
    pe_error = 4'b0000;
    wait_done("pe_err done", 30);
    chk("pe_err sticky", run_err, 1'b1);

    // Reset mid-FEED
    do_start(4);
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("rst a1_valid", a1_valid, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst run_err", run_err, 1'b0);
    do_start(2);
    chk("rst buf cleared valid", a1_valid, 1'b1);
    chk("rst buf cleared dat", a1_dat, 32'h0);
    wait_done("rst done", 20);
    load_nominal();
    do_start(3);
    chk("rst reload a1", a1_dat, F1);
    wait_done("rst reload done", 20);

    // Randomized traffic; the compare process checks every cycle
    for (int c = 0; c < 4000; c++) begin
      rst          = ($urandom_range(0, 599) == 0);
      a1_ready     = ($urandom_range(0, 3) != 0);
      a2_ready     = ($urandom_range(0, 3) != 0);
      b1_ready     = ($urandom_range(0, 3) != 0);
      b2_ready     = ($urandom_range(0, 3) != 0);
      pe_comp_done = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom);
      pe_error     = ($urandom_range(0, 59) == 0) ? 4'($urandom) : 4'h0;
      ld_en        = ($urandom_range(0, 1) == 0);
      ld_sel       = 2'($urandom);
      ld_idx       = 3'($urandom);
      ld_dat       = $urandom;
      start        = ($urandom_range(0, 7) == 0);
      k_len        = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15) * $urandom_range(0, 1))
                                                 : 4'($urandom_range(1, 8));
      tick();
    end
    rst = 0; start = 0; ld_en = 0; pe_error = 0; pe_comp_done = 4'hF;
    a1_ready = 1; a2_ready = 1; b1_ready = 1; b2_ready = 1;
    n = 0;
    while (busy && n < 200) begin tick(); n++; end
    chk("final idle", busy, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sys_array_sched.md
# sys_array_sched

Operand scheduler for the 2x2 floating-point systolic array. It holds the A-row and B-column operand buffers, which are loaded through a simple write port. On `start` it streams the operands into the four array edge ports with the required one-handshake skew between row/column 1 and row/column 2. It then waits for all PEs to report completion and pulses `done`, and it flags configuration, PE and timeout errors.

## Interface
- `N_MAX`, 8: max inner dimension (operands per row/column buffer).
- `DW`, 32: operand width (single-precision float bits, `SNGL_FLT_SIZE`).
- `DRAIN_TO`, 64: max cycles in DRAIN before timeout.
- Clock/reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  begin a computation; honoured only in IDLE.
- `k_len`  in  $clog2(N_MAX)+1  inner dimension, sampled on accepted `start`; legal range 1..N_MAX.
- `ld_en`  in  1  buffer write strobe; honoured only in IDLE.
- `ld_sel`  in  2  buffer select: 0 = A row1, 1 = A row2, 2 = B col1, 3 = B col2.
- `ld_idx`  in  $clog2(N_MAX)  element index within the selected buffer.
- `ld_dat`  in  DW  element value.
- `a1_dat`, `a2_dat`, `b1_dat`, `b2_dat`  out  DW each  edge data to r1c1 row, r2c1 row, r1c1 col, r1c2 col.
- `a1_valid`, `a2_valid`, `b1_valid`, `b2_valid`  out  1 each  edge valids.
- `a1_ready`, `a2_ready`, `b1_ready`, `b2_ready`  in  1 each  edge readies from the PEs.
- `pe_comp_done`  in  4  per-PE comp_done, ordered {r2c2, r2c1, r1c2, r1c1}.
- `pe_error`  in  4  per-PE error bits, same order.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a computation completes.
- `cfg_err`  out  1  sticky; set by an illegal `k_len`.
- `run_err`  out  1  sticky; set by a PE error or a drain timeout.

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- **IDLE**
  - `ld_en` writes `ld_dat` into `buf[ld_sel][ld_idx]`.
  - `start` with `k_len` in 1..N_MAX: latch `k_len`, clear `cfg_err` and `run_err`, clear counters, go to FEED.
  - `start` with `k_len` = 0 or > N_MAX: set `cfg_err`, stay in IDLE, no `done`.
- **FEED, group 1 (a1/b1)**
  - `a1_valid` = `b1_valid` = (`cnt1` < K).
  - Data is `bufA1[cnt1]` / `bufB1[cnt1]`.
  - Group 1 advances (`cnt1`++) only when `a1_valid & a1_ready & b1_valid & b1_ready`.
- **FEED, group 2 (a2/b2)**
  - `a2_valid` = `b2_valid` = `g2_en & (cnt2 < K)`.
  - `g2_en` sets in the cycle after the first group-1 handshake.
  - Group 2 advances under the same joint rule using all four group-2 signals.
- **Handshake rules**
  - Data and valid are held stable while valid is high and the joint handshake has not occurred.
  - Valid is never deasserted without a handshake.
- FEED -> DRAIN when `cnt1` == K and `cnt2` == K.
- **DRAIN**
  - All valids are low.
  - The drain counter increments each cycle.
  - `pe_comp_done` == 4'b1111 -> DONE.
  - Drain counter reaching DRAIN_TO -> set `run_err`, go to DONE.
- **DONE**: `done` = 1 for exactly one cycle, then IDLE.
- Any `pe_error` bit high in FEED or DRAIN sets `run_err` (sticky); sequencing continues.
- `ld_en` and `start` are ignored while `busy`.
- Counters are $clog2(N_MAX)+1 bits wide and never wrap; each saturates at K.
- **Reset**: synchronous, high. Mid-operation it aborts to IDLE.
  - All buffers, counters and `g2_en` clear to 0.
  - All outputs (valids, `busy`, `done`, `cfg_err`, `run_err`) go low; `*_dat` reads 0.

## Timing
- `start` accepted at cycle t -> FEED at t+1; `a1_valid`/`b1_valid` high at t+1 with element 0.
- With all readies high:
  - Group 1 handshakes occur at t+1..t+K.
  - Group 2 handshakes occur at t+2..t+K+1.
  - DRAIN begins at t+K+2.
- `done` is asserted in the cycle after `pe_comp_done` is first sampled at all-ones in DRAIN.
- A `ld_en` and a `start` in the same IDLE cycle: the write lands, and element 0 is read from the updated buffer at t+1.
- The `cfg_err` update takes effect the cycle after the illegal `start`.

## Test plan
- **Nominal K=3**
  - Stimulus: load A1={1,2,3}, A2={4,5,6}, B1={1,2,3}, B2={4,5,6}, readies high; `start` at t; `pe_comp_done` = 4'hF at t+8.
  - Required: a1 carries 1,2,3 at t+1..t+3; a2 carries 4,5,6 at t+2..t+4; DRAIN at t+5; `done` pulse at t+9.
- **Backpressure**
  - Stimulus: `b1_ready` low at t+2..t+4.
  - Required: a1 and b1 hold element 1 (value 2.0); `cnt1` frozen; group 2 unaffected; total FEED lengthens by 3 cycles.
- **Illegal config**
  - Stimulus: `start` with `k_len`=0, then with `k_len`=9.
  - Required: `cfg_err`=1, `busy` stays 0, no valids, no `done`; a later legal `start` clears `cfg_err`.
- **Timeout and PE error**
  - Stimulus: `pe_comp_done` stuck at 4'b0111; separately, `pe_error[2]` pulses during FEED.
  - Required: the stuck case gives `run_err`=1 and `done` after DRAIN_TO drain cycles; the error pulse gives `run_err`=1 sticky with the K handshakes still completed.
- **Ignored inputs while busy**
  - Stimulus: `ld_en` writing A1[0]=9.0 during FEED; a second `start` during DRAIN.
  - Required: the buffer is unchanged (reread after `done` shows 1.0); no restart.
- **Reset mid-FEED**
  - Stimulus: `rst` high after 2 group-1 handshakes.
  - Required: next cycle all valids=0, `busy`=0, buffers read 0; a new load plus `start` completes normally.
